tlb_ctrl: RTL and testbench

- CP0-side controller for the TLB: sequences TLBP/TLBR/TLBWI/TLBWR from the execute stage into the MMU's one-cycle strobes and captures the MMU's CP0 outputs as registered write-backs.
- Owns the Random register.
- Turns the MMU's found/valid/writeable lookup results into registered TLB exceptions (Refill/Invalid on TLBL/TLBS, Mod), with BadVAddr, EntryHi and Context update data.

---
 rtl/tlb_ctrl_pkg.sv | 32 +++
 rtl/tlb_ctrl_if.sv | 69 ++++++
 rtl/tlb_ctrl_random.sv | 29 ++
 rtl/tlb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tlb_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_ctrl_pkg.sv
// Shared types and constants for the CP0-side TLB controller.
// TLB_LINE/TLB_WIDTH track tlb_defines.vh.
package tlb_pkg;

  localparam int unsigned TLB_LINE  = 32;
  localparam int unsigned TLB_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } tlb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WB
  } tlb_state_e;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  typedef struct packed {
    logic        valid;
    logic        refill;
    logic [4:0]  code;
    logic [31:0] badvaddr;
  } tlb_exc_t;

endpackage

// File: rtl/tlb_ctrl_if.sv
// Execute/MMU/CP0 signal bundle around tlb_ctrl; slave is the controller side.
interface tlb_ctrl_if #(
  parameter int unsigned TLB_WIDTH = 5
);
  logic                 op_valid;
  logic [1:0]           op;
  logic                 op_ready;
  logic                 op_done;
  logic                 tlbp;
  logic                 tlbr;
  logic                 tlbwi;
  logic                 tlbwr;
  logic [31:0]          random_out;
  logic [TLB_WIDTH-1:0] wired_in;
  logic                 wired_we;
  logic [31:0]          mmu_index;
  logic [31:0]          mmu_pagemask;
  logic [31:0]          mmu_entrylo0;
  logic [31:0]          mmu_entrylo1;
  logic [31:0]          mmu_entryhi;
  logic                 cp0_index_we;
  logic                 cp0_tlbr_we;
  logic [31:0]          cp0_index;
  logic [31:0]          cp0_pagemask;
  logic [31:0]          cp0_entrylo0;
  logic [31:0]          cp0_entrylo1;
  logic [31:0]          cp0_entryhi;
  logic                 inst_req;
  logic                 inst_found;
  logic                 inst_valid;
  logic [31:0]          inst_vaddr;
  logic                 data_req;
  logic                 data_we;
  logic                 data_found;
  logic                 data_valid;
  logic                 data_writeable;
  logic [31:0]          data_vaddr;
  logic                 flush;
  logic                 exc_valid;
  logic                 exc_refill;
  logic [4:0]           exc_code;
  logic [31:0]          exc_badvaddr;
  logic [18:0]          exc_vpn2;

  modport slave (
    input  op_valid, op, wired_in, wired_we,
    input  mmu_index, mmu_pagemask, mmu_entrylo0, mmu_entrylo1, mmu_entryhi,
    input  inst_req, inst_found, inst_valid, inst_vaddr,
    input  data_req, data_we, data_found, data_valid, data_writeable, data_vaddr,
    input  flush,
    output op_ready, op_done, tlbp, tlbr, tlbwi, tlbwr, random_out,
    output cp0_index_we, cp0_tlbr_we,
    output cp0_index, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_entryhi,
    output exc_valid, exc_refill, exc_code, exc_badvaddr, exc_vpn2
  );

  modport master (
    output op_valid, op, wired_in, wired_we,
    output mmu_index, mmu_pagemask, mmu_entrylo0, mmu_entrylo1, mmu_entryhi,
    output inst_req, inst_found, inst_valid, inst_vaddr,
    output data_req, data_we, data_found, data_valid, data_writeable, data_vaddr,
    output flush,
    input  op_ready, op_done, tlbp, tlbr, tlbwi, tlbwr, random_out,
    input  cp0_index_we, cp0_tlbr_we,
    input  cp0_index, cp0_pagemask, cp0_entrylo0, cp0_entrylo1, cp0_entryhi,
    input  exc_valid, exc_refill, exc_code, exc_badvaddr, exc_vpn2
  );

endinterface

// File: rtl/tlb_ctrl_random.sv
// CP0 Random register: counts down from TLB_LINE-1 to Wired, then wraps.
module tlb_random #(
  parameter int unsigned TLB_LINE  = 32,
  parameter int unsigned TLB_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wired_we,
  input  logic                 i_freeze,
  input  logic [TLB_WIDTH-1:0] i_wired,
  output logic [TLB_WIDTH-1:0] o_random
);

  localparam logic [TLB_WIDTH-1:0] RAND_TOP = TLB_WIDTH'(TLB_LINE - 1);

  logic [TLB_WIDTH-1:0] r_random;

  // Wired >= TOP makes the wrap test always true, pinning Random at TOP.
  always_ff @(posedge clk) begin
    if (rst || i_wired_we) begin
      r_random <= RAND_TOP;
    end else if (!i_freeze) begin
      r_random <= (r_random <= i_wired) ? RAND_TOP : r_random - 1'b1;
    end
  end

  assign o_random = r_random;

endmodule

// File: rtl/tlb_ctrl.sv
// Sequences TLB instructions into MMU strobes, owns Random, and registers
// TLB lookup faults as exceptions with BadVAddr/VPN2 data.
module tlb_ctrl #(
  parameter int unsigned TLB_LINE  = tlb_pkg::TLB_LINE,
  parameter int unsigned TLB_WIDTH = tlb_pkg::TLB_WIDTH
) (
  input logic       clk,
  input logic       rst,
  tlb_ctrl_if.slave bus
);
  import tlb_pkg::*;

  tlb_state_e           r_state;
  tlb_state_e           w_state_nxt;
  tlb_op_e              r_op;
  logic                 w_op_ready;
  logic                 w_op_done;
  logic                 w_tlbp;
  logic                 w_tlbr;
  logic                 w_tlbwi;
  logic                 w_tlbwr;
  logic                 w_index_we;
  logic                 w_tlbr_we;
  logic                 w_freeze;
  logic [TLB_WIDTH-1:0] w_random;
  logic [31:0]          r_cp0_index;
  logic [31:0]          r_cp0_pagemask;
  logic [31:0]          r_cp0_entrylo0;
  logic [31:0]          r_cp0_entrylo1;
  logic [31:0]          r_cp0_entryhi;
  tlb_exc_t             w_exc_nxt;
  tlb_exc_t             r_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_TLBP;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && bus.op_valid) begin
        r_op <= tlb_op_e'(bus.op);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_ready  = 1'b0;
    w_op_done   = 1'b0;
    w_tlbp      = 1'b0;
    w_tlbr      = 1'b0;
    w_tlbwi     = 1'b0;
    w_tlbwr     = 1'b0;
    w_index_we  = 1'b0;
    w_tlbr_we   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_op_ready = 1'b1;
        if (bus.op_valid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        case (r_op)
          OP_TLBP:  w_tlbp  = 1'b1;
          OP_TLBR:  w_tlbr  = 1'b1;
          OP_TLBWI: w_tlbwi = 1'b1;
          OP_TLBWR: w_tlbwr = 1'b1;
        endcase
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        w_op_done   = 1'b1;
        w_index_we  = (r_op == OP_TLBP);
        w_tlbr_we   = (r_op == OP_TLBR);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cp0_index    <= '0;
      r_cp0_pagemask <= '0;
      r_cp0_entrylo0 <= '0;
      r_cp0_entrylo1 <= '0;
      r_cp0_entryhi  <= '0;
    end else if (r_state == ST_ISSUE) begin
      case (r_op)
        OP_TLBP: r_cp0_index <= bus.mmu_index;
        OP_TLBR: begin
          r_cp0_pagemask <= bus.mmu_pagemask;
          r_cp0_entrylo0 <= bus.mmu_entrylo0;
          r_cp0_entrylo1 <= bus.mmu_entrylo1;
          r_cp0_entryhi  <= bus.mmu_entryhi;
        end
        default: ;
      endcase
    end
  end

  // Holding Random through the TLBWR strobe makes the written slot match random_out.
  assign w_freeze = (r_state == ST_ISSUE) && (r_op == OP_TLBWR);

  tlb_random #(
    .TLB_LINE (TLB_LINE),
    .TLB_WIDTH(TLB_WIDTH)
  ) u_random (
    .clk       (clk),
    .rst       (rst),
    .i_wired_we(bus.wired_we),
    .i_freeze  (w_freeze),
    .i_wired   (bus.wired_in),
    .o_random  (w_random)
  );

  always_comb begin
    w_exc_nxt = '0;
    if (bus.inst_req && !bus.inst_found) begin
      w_exc_nxt = '{valid: 1'b1, refill: 1'b1, code: EXC_TLBL, badvaddr: bus.inst_vaddr};
    end else if (bus.inst_req && !bus.inst_valid) begin
      w_exc_nxt = '{valid: 1'b1, refill: 1'b0, code: EXC_TLBL, badvaddr: bus.inst_vaddr};
    end else if (bus.data_req && !w_tlbp) begin
      if (!bus.data_found) begin
        w_exc_nxt = '{valid: 1'b1, refill: 1'b1,
                      code: bus.data_we ? EXC_TLBS : EXC_TLBL, badvaddr: bus.data_vaddr};
      end else if (!bus.data_valid) begin
        w_exc_nxt = '{valid: 1'b1, refill: 1'b0,
                      code: bus.data_we ? EXC_TLBS : EXC_TLBL, badvaddr: bus.data_vaddr};
      end else if (bus.data_we && !bus.data_writeable) begin
        w_exc_nxt = '{valid: 1'b1, refill: 1'b0, code: EXC_MOD, badvaddr: bus.data_vaddr};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_exc <= '0;
    end else begin
      r_exc <= w_exc_nxt;
    end
  end

  assign bus.op_ready     = w_op_ready;
  assign bus.op_done      = w_op_done;
  assign bus.tlbp         = w_tlbp;
  assign bus.tlbr         = w_tlbr;
  assign bus.tlbwi        = w_tlbwi;
  assign bus.tlbwr        = w_tlbwr;
  assign bus.random_out   = 32'(w_random);
  assign bus.cp0_index_we = w_index_we;
  assign bus.cp0_tlbr_we  = w_tlbr_we;
  assign bus.cp0_index    = r_cp0_index;
  assign bus.cp0_pagemask = r_cp0_pagemask;
  assign bus.cp0_entrylo0 = r_cp0_entrylo0;
  assign bus.cp0_entrylo1 = r_cp0_entrylo1;
  assign bus.cp0_entryhi  = r_cp0_entryhi;
  assign bus.exc_valid    = r_exc.valid;
  assign bus.exc_refill   = r_exc.refill;
  assign bus.exc_code     = r_exc.code;
  assign bus.exc_badvaddr = r_exc.badvaddr;
  assign bus.exc_vpn2     = r_exc.badvaddr[31:13];

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomized bench for tlb_ctrl against a cycle-indexed behavioural model,
// plus directed literal checks that pin the model.
module tb_tlb_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlb_ctrl_if #(.TLB_WIDTH(5)) bus();

  tlb_ctrl #(.TLB_LINE(32), .TLB_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // Model: an accepted op occupies cycles m_issue (strobe) and m_issue+1 (done).
  int          m_cyc   = 0;
  int          m_issue = -100;
  int          m_op    = 0;
  int          m_rnd   = 31;
  logic [31:0] m_idx = '0, m_pm = '0, m_lo0 = '0, m_lo1 = '0, m_hi = '0;
  bit          m_ev = 0, m_er = 0;
  int          m_code = 0;
  logic [31:0] m_bad = '0;

  always @(posedge clk) begin : model
    int c;
    bit iss, wb, idle, stp;
    c    = m_cyc;
    iss  = (c == m_issue);
    wb   = (c == m_issue + 1);
    idle = !iss && !wb;
    stp  = iss && (m_op == 0);
    if (rst) begin
      m_issue = -100;
      m_rnd = 31;
      m_idx = '0; m_pm = '0; m_lo0 = '0; m_lo1 = '0; m_hi = '0;
      m_ev = 0; m_er = 0; m_code = 0; m_bad = '0;
    end else begin
      if (bus.wired_we) m_rnd = 31;
      else if (!(iss && m_op == 3)) m_rnd = (m_rnd <= int'(bus.wired_in)) ? 31 : m_rnd - 1;
      if (iss && m_op == 0) m_idx = bus.mmu_index;
      if (iss && m_op == 1) begin
        m_pm = bus.mmu_pagemask; m_lo0 = bus.mmu_entrylo0;
        m_lo1 = bus.mmu_entrylo1; m_hi = bus.mmu_entryhi;
      end
      if (idle && bus.op_valid) begin
        m_issue = c + 1;
        m_op = int'(bus.op);
      end
      m_ev = 0; m_er = 0; m_code = 0; m_bad = '0;
      if (!bus.flush) begin
        if (bus.inst_req && (!bus.inst_found || !bus.inst_valid)) begin
          m_ev = 1; m_er = !bus.inst_found; m_code = 2; m_bad = bus.inst_vaddr;
        end else if (bus.data_req && !stp) begin
          m_bad = bus.data_vaddr;
          if (!bus.data_found || !bus.data_valid) begin
            m_ev = 1; m_er = !bus.data_found; m_code = bus.data_we ? 3 : 2;
          end else if (bus.data_we && !bus.data_writeable) begin
            m_ev = 1; m_code = 1;
          end else begin
            m_bad = '0;
          end
        end
      end
    end
    m_cyc = c + 1;
  end

  always @(negedge clk) begin : compare
    bit iss, wb;
    if (chk_en) begin
      iss = (m_cyc == m_issue);
      wb  = (m_cyc == m_issue + 1);
      chk("op_ready", 32'(bus.op_ready), 32'(!(iss || wb)));
      chk("op_done",  32'(bus.op_done),  32'(wb));
      chk("strobes",  {28'd0, bus.tlbwr, bus.tlbwi, bus.tlbr, bus.tlbp},
          iss ? (32'd1 << m_op) : 32'd0);
      chk("index_we", 32'(bus.cp0_index_we), 32'(wb && m_op == 0));
      chk("tlbr_we",  32'(bus.cp0_tlbr_we),  32'(wb && m_op == 1));
      chk("random",   bus.random_out, 32'(m_rnd));
      if (wb && m_op == 0) chk("cp0_index", bus.cp0_index, m_idx);
      if (wb && m_op == 1) begin
        chk("cp0_pagemask", bus.cp0_pagemask, m_pm);
        chk("cp0_entrylo0", bus.cp0_entrylo0, m_lo0);
        chk("cp0_entrylo1", bus.cp0_entrylo1, m_lo1);
        chk("cp0_entryhi",  bus.cp0_entryhi,  m_hi);
      end
      chk("exc_valid",    32'(bus.exc_valid),  32'(m_ev));
      chk("exc_refill",   32'(bus.exc_refill), 32'(m_er));
      chk("exc_code",     32'(bus.exc_code),   32'(m_code));
      chk("exc_badvaddr", bus.exc_badvaddr,    m_bad);
      chk("exc_vpn2",     32'(bus.exc_vpn2),   32'(m_bad[31:13]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus.op_valid = 0; bus.op = '0; bus.wired_in = '0; bus.wired_we = 0;
    bus.mmu_index = '0; bus.mmu_pagemask = '0; bus.mmu_entrylo0 = '0;
    bus.mmu_entrylo1 = '0; bus.mmu_entryhi = '0;
    bus.inst_req = 0; bus.inst_found = 0; bus.inst_valid = 0; bus.inst_vaddr = '0;
    bus.data_req = 0; bus.data_we = 0; bus.data_found = 0; bus.data_valid = 0;
    bus.data_writeable = 0; bus.data_vaddr = '0; bus.flush = 0;
  endtask

  initial begin
    bit seen;
    clear_inputs();
    rst = 1;
    cyc(2);
    chk_en = 1;
    chk("rst_ready",  32'(bus.op_ready), 32'd1);
    chk("rst_random", bus.random_out,    32'd31);
    chk("rst_exc",    32'(bus.exc_valid), 32'd0);
    chk("rst_index",  bus.cp0_index,     32'd0);
    rst = 0;

    // Countdown 30..0 then wrap to 31 with Wired = 0
    for (int k = 1; k <= 32; k++) begin
      cyc(1);
      chk("rnd_seq", bus.random_out, 32'((31 - k) & 31));
    end

    bus.wired_in = 5'd28; bus.wired_we = 1;
    cyc(1);
    bus.wired_we = 0;
    chk("wired_31", bus.random_out, 32'd31);
    cyc(1); chk("wired_30", bus.random_out, 32'd30);
    cyc(1); chk("wired_29", bus.random_out, 32'd29);
    cyc(1); chk("wired_28", bus.random_out, 32'd28);
    cyc(1); chk("wired_wrap", bus.random_out, 32'd31);

    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.random_out == 32'd30) seen = 1;
      else cyc(1);
    end
    chk("rnd_wait30", 32'(seen), 32'd1);
    bus.op_valid = 1; bus.op = 2'd3;
    cyc(1);
    bus.op_valid = 0;
    chk("wr_strobe", 32'(bus.tlbwr), 32'd1);
    chk("wr_rand",   bus.random_out, 32'd29);
    cyc(1);
    chk("wr_done",   32'(bus.op_done), 32'd1);
    chk("wr_frozen", bus.random_out, 32'd29);
    cyc(1);
    chk("wr_resume", bus.random_out, 32'd28);
    bus.wired_in = '0;

    bus.mmu_index = 32'h0000_0007; bus.op_valid = 1; bus.op = 2'd0;
    cyc(1);
    bus.op_valid = 0;
    chk("p_strobe", 32'(bus.tlbp), 32'd1);
    chk("p_ready",  32'(bus.op_ready), 32'd0);
    cyc(1);
    chk("p_done",  32'(bus.op_done), 32'd1);
    chk("p_we",    32'(bus.cp0_index_we), 32'd1);
    chk("p_index", bus.cp0_index, 32'd7);
    chk("p_nostb", 32'(bus.tlbp), 32'd0);
    cyc(1);
    chk("p_idle", 32'(bus.op_ready), 32'd1);

    bus.mmu_index = 32'h8000_0000; bus.op_valid = 1; bus.op = 2'd0;
    cyc(1);
    bus.op_valid = 0;
    cyc(1);
    chk("p_miss", bus.cp0_index, 32'h8000_0000);
    cyc(1);

    bus.mmu_entryhi = 32'h1234_5000; bus.mmu_pagemask = 32'h0001_e000;
    bus.op_valid = 1; bus.op = 2'd1;
    cyc(1);
    bus.op_valid = 0;
    chk("r_ready1", 32'(bus.op_ready), 32'd0);
    chk("r_strobe", 32'(bus.tlbr), 32'd1);
    cyc(1);
    chk("r_ready2", 32'(bus.op_ready), 32'd0);
    chk("r_we",     32'(bus.cp0_tlbr_we), 32'd1);
    chk("r_hi",     bus.cp0_entryhi, 32'h1234_5000);
    chk("r_pm",     bus.cp0_pagemask, 32'h0001_e000);
    cyc(1);
    chk("r_idle",   32'(bus.op_ready), 32'd1);

    bus.data_req = 1; bus.data_we = 1; bus.data_found = 1; bus.data_valid = 1;
    bus.data_writeable = 0; bus.data_vaddr = 32'h0040_2abc;
    cyc(1);
    bus.data_req = 0;
    chk("mod_valid",  32'(bus.exc_valid), 32'd1);
    chk("mod_code",   32'(bus.exc_code), 32'd1);
    chk("mod_refill", 32'(bus.exc_refill), 32'd0);
    chk("mod_vpn2",   32'(bus.exc_vpn2), 32'h0000_0201);
    cyc(1);
    chk("mod_once",   32'(bus.exc_valid), 32'd0);

    bus.inst_req = 1; bus.inst_found = 0; bus.inst_vaddr = 32'hbfc0_1234;
    bus.data_req = 1; bus.data_we = 1; bus.data_found = 0; bus.data_vaddr = 32'h0000_1000;
    cyc(1);
    chk("dual_valid",  32'(bus.exc_valid), 32'd1);
    chk("dual_code",   32'(bus.exc_code), 32'd2);
    chk("dual_refill", 32'(bus.exc_refill), 32'd1);
    chk("dual_bad",    bus.exc_badvaddr, 32'hbfc0_1234);
    bus.flush = 1;
    cyc(1);
    chk("flush_clr",   32'(bus.exc_valid), 32'd0);
    clear_inputs();

    bus.op_valid = 1; bus.op = 2'd2;
    cyc(1);
    bus.op_valid = 0;
    chk("wi_strobe", 32'(bus.tlbwi), 32'd1);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("rst_mid_ready",  32'(bus.op_ready), 32'd1);
    chk("rst_mid_strobe", 32'(bus.tlbwi), 32'd0);
    chk("rst_mid_done",   32'(bus.op_done), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      bus.op_valid       = ($urandom_range(0, 2) == 0);
      bus.op             = 2'($urandom_range(0, 3));
      bus.wired_we       = ($urandom_range(0, 39) == 0);
      if (bus.wired_we) bus.wired_in = 5'($urandom_range(0, 31));
      bus.mmu_index      = $urandom;
      bus.mmu_pagemask   = $urandom;
      bus.mmu_entrylo0   = $urandom;
      bus.mmu_entrylo1   = $urandom;
      bus.mmu_entryhi    = $urandom;
      bus.inst_req       = ($urandom_range(0, 3) == 0);
      bus.inst_found     = ($urandom_range(0, 3) != 0);
      bus.inst_valid     = ($urandom_range(0, 3) != 0);
      bus.inst_vaddr     = $urandom;
      bus.data_req       = $urandom_range(0, 1) != 0;
      bus.data_we        = $urandom_range(0, 1) != 0;
      bus.data_found     = ($urandom_range(0, 3) != 0);
      bus.data_valid     = ($urandom_range(0, 3) != 0);
      bus.data_writeable = $urandom_range(0, 1) != 0;
      bus.data_vaddr     = $urandom;
      bus.flush          = ($urandom_range(0, 7) == 0);
      rst                = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 0;
    clear_inputs();
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
